ascon_share_loader: RTL and testbench
=====================================

Name: ascon_share_loader

Overview:
- Upstream stage of the masked Ascon encryption core.
- Accepts parallel key, nonce, associated data and plaintext plus a PRNG seed through a valid/ready handshake.
- Splits each operand into three Boolean shares and streams them MSB-first, one bit per cycle, together with the per-cycle fault/random bits the core consumes.
- Re-aligns the core with a one-cycle reset pulse, then asserts start and holds it until the core reports ready.

Parameters:
- K, 128: key width in bits.
- L, 32: associated-data width.
- Y, 32: plaintext width.
- SETTLE, 2: idle cycles between last stream beat and start assertion.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  operand set presented.
- load_ready  output  1  loader idle; load accepted when load_valid & load_ready.
- key  input  K  secret key.
- nonce  input  128  nonce.
- ad  input  L  associated data.
- pt  input  Y  plaintext.
- seed  input  64  PRNG seed, sampled on load.
- core_rstxSO  output  1  one-cycle reset pulse to core.
- keyxSO  output  3  key shares {m2, m1, d^m1^m2}; bit0 is the masked data share.
- noncexSO  output  3  nonce shares, same layout.
- associated_dataxSO  output  3  AD shares, same layout.
- plain_textxSO  output  3  plaintext shares, same layout.
- r_64xSO  output  7  seven fresh random bits per beat.
- r_128xSO  output  1  fault-randomness bit, 128-bit stream.
- r_ptxSO  output  1  fault-randomness bit, Y-bit stream.
- encryption_startxSO  output  1  start request to core.
- encryption_readyxSI  input  1  core finished.
- busy  output  1  high in any state except IDLE.

Behaviour:
- States: IDLE, PULSE, STREAM, SETTLE, START.
- Reset: state=IDLE; all outputs 0 except load_ready=1; beat counter 0; operand registers 0.
- IDLE → PULSE on load_valid & load_ready:
  - Operands are registered.
  - PRNG state is loaded with seed; seed==0 is replaced by 64'h1.
- PULSE: core_rstxSO=1 for exactly one cycle → STREAM.
- STREAM: beat counter n = 0..N-1, with N = max(K,128,L,Y,64).
  - Beat n drives operand bit [W-1-n] for every lane of width W while n<W; the lane drives 0 once n>=W.
  - Random lanes follow the same rule: r_64xSO for n<64, r_128xSO for n<128, r_ptxSO for n<Y.
  - Beat 0 appears in the cycle immediately after the core_rstxSO cycle.
  - n=N-1 → SETTLE.
- SETTLE: all stream outputs 0 for SETTLE cycles → START.
- START: encryption_startxSO=1, held until encryption_readyxSI=1 is sampled; then → IDLE the next cycle and encryption_startxSO drops.
- Masks: each beat consumes 17 fresh PRNG bits, bit 0 first:
  - bits[7:0] → (m1,m2) for key, nonce, AD, PT in that order;
  - bits[14:8] → r_64xSO;
  - bit 15 → r_128xSO;
  - bit 16 → r_ptxSO.
  - The PRNG advances only in STREAM.
- Share invariant: XOR of the three bits of every lane equals the operand bit.
- load_valid outside IDLE is ignored; load_ready=0.
- encryption_readyxSI outside START is ignored.
- rst in any state aborts immediately to IDLE; core_rstxSO is not pulsed by rst itself.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro ASCON_LOADER_NOMASK_EN, a debug build.
- Defined: m1=m2=0, so lane bit0 carries raw data and bits[2:1]=0; random lanes are still driven from the PRNG.
- Undefined: full masking as above.

Decomposition:
- Package ascon_loader_pkg:
  - state encoding enum;
  - PRNG polynomial constant 64'hD800_0000_0000_0000 (taps 64,63,61,60);
  - BITS_PER_BEAT=17;
  - function max4 for N.
- One sub-module, ascon_mask_prng:
  - 64-bit Galois LFSR unrolled 17 steps per cycle;
  - ports clk, rst, load, seed, advance, bits[16:0].

Test Plan:
- Reset then load_valid=1 with key=128'h000102…0F, nonce=128'hA5…A5, ad=32'hDEADBEEF, pt=32'h01234567, seed=64'h1 → load_ready drops next cycle; core_rstxSO=1 for 1 cycle; busy=1.
- Capture 128 beats with a shift-left model → XOR of the three key shares reassembles 128'h000102…0F; AD/PT reassemble exactly; AD/PT lanes are 0 for beats 32..127.
- Same load twice with seeds 64'h1 and 64'h2 → reassembled data identical, share bits differ; seed=0 gives output identical to seed=64'h1.
- Hold encryption_readyxSI=0 for 500 cycles after START → encryption_startxSO stays 1; ready=1 → IDLE next cycle, load_ready=1.
- Assert rst at beat 40 → all outputs 0 the next cycle, state IDLE; a new load restarts from core_rstxSO pulse and beat 0.
- Build with ASCON_LOADER_NOMASK_EN, pt=32'hFFFF0000 → plain_textxSO[0] streams 16 ones then 16 zeros; bits[2:1]=0 throughout.

Source files
------------

// File: rtl/ascon_loader_pkg.sv
// ascon_loader_pkg: shared types and constants for the Ascon share loader
//   state_t       loader FSM states
//   PRNG_POLY     Galois LFSR feedback mask (taps 64,63,61,60)
//   BITS_PER_BEAT PRNG bits consumed per stream beat
//   max4          widest of four lane widths
package ascon_loader_pkg;
   typedef enum logic [2:0] {S_IDLE, S_PULSE, S_STREAM, S_SETTLE, S_START} state_t;
   localparam logic [63:0] PRNG_POLY = 64'hD800_0000_0000_0000;
   localparam int BITS_PER_BEAT = 17;
   function automatic int max4(input int a, input int b, input int c, input int d);
      int x;
      x = a > b ? a : b;
      x = x > c ? x : c;
      return x > d ? x : d;
   endfunction
endpackage

// File: rtl/ascon_mask_prng.sv
// ascon_mask_prng: 64-bit Galois LFSR producing 17 mask bits per advance
//   clk, rst  clock, synchronous active-high reset
//   load      capture seed (zero seed replaced by 1 to avoid the lock-up state)
//   seed      64-bit seed
//   advance   step the LFSR 17 times
//   bits      next 17 output bits, bit 0 produced first
module ascon_mask_prng
   import ascon_loader_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [63:0]              seed,
   input  logic                     advance,
   output logic [BITS_PER_BEAT-1:0] bits
);
   logic [63:0] st, s;
   always_comb begin
      s = st;
      bits = '0;
      for (int i = 0; i < BITS_PER_BEAT; i++) begin
         bits[i] = s[0];
         s = (s >> 1) ^ (s[0] ? PRNG_POLY : 64'h0);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) st <= 64'h1;
      else if (load) st <= seed == 64'h0 ? 64'h1 : seed;
      else if (advance) st <= s;
   end
endmodule

// File: rtl/ascon_share_loader.sv
// ascon_share_loader: splits operands into three Boolean shares and streams them MSB-first to the masked Ascon core
//   load_valid/load_ready       operand handshake (key, nonce, ad, pt, seed)
//   core_rstxSO                 one-cycle core re-align pulse
//   *xSO share lanes            {m2, m1, d^m1^m2}, one bit per beat
//   r_64xSO/r_128xSO/r_ptxSO    per-beat random bits
//   encryption_startxSO/readyxSI start request held until core ready
//   busy                        loader not idle
//   ASCON_LOADER_NOMASK_EN      debug build: masks forced to zero
module ascon_share_loader
   import ascon_loader_pkg::*;
#(
   parameter int K      = 128,
   parameter int L      = 32,
   parameter int Y      = 32,
   parameter int SETTLE = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [K-1:0] key,
   input  logic [127:0] nonce,
   input  logic [L-1:0] ad,
   input  logic [Y-1:0] pt,
   input  logic [63:0]  seed,
   output logic         core_rstxSO,
   output logic [2:0]   keyxSO,
   output logic [2:0]   noncexSO,
   output logic [2:0]   associated_dataxSO,
   output logic [2:0]   plain_textxSO,
   output logic [6:0]   r_64xSO,
   output logic         r_128xSO,
   output logic         r_ptxSO,
   output logic         encryption_startxSO,
   input  logic         encryption_readyxSI,
   output logic         busy
);
   localparam int N  = max4(max4(K, 128, L, Y), 64, 0, 0);
   localparam int CW = $clog2(N) + 1;
   state_t state, state_d;
   logic [CW-1:0] n, nb;
   logic [K-1:0] key_q;
   logic [127:0] nonce_q;
   logic [L-1:0] ad_q;
   logic [Y-1:0] pt_q;
   logic [BITS_PER_BEAT-1:0] p;
   logic [7:0] m;
   logic accept, emit;
   function automatic logic [2:0] share(input logic d, input logic m1, input logic m2, input logic on);
      return on ? {m2, m1, d ^ m1 ^ m2} : 3'b000;
   endfunction
   assign accept = state == S_IDLE && load_valid;
   assign emit   = state_d == S_STREAM;
   // outputs are registered, so the beat loaded at this edge is the one after the current one
   assign nb     = state == S_PULSE ? '0 : n + 1'b1;
`ifdef ASCON_LOADER_NOMASK_EN
   assign m = '0;
`else
   assign m = p[7:0];
`endif
   ascon_mask_prng u_prng (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .seed    (seed),
      .advance (emit),
      .bits    (p)
   );
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:   state_d = load_valid ? S_PULSE : S_IDLE;
         S_PULSE:  state_d = S_STREAM;
         S_STREAM: state_d = n == CW'(N - 1) ? S_SETTLE : S_STREAM;
         S_SETTLE: state_d = n == CW'(SETTLE - 1) ? S_START : S_SETTLE;
         S_START:  state_d = encryption_readyxSI ? S_IDLE : S_START;
         default:  state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= S_IDLE;
         n                   <= '0;
         key_q               <= '0;
         nonce_q             <= '0;
         ad_q                <= '0;
         pt_q                <= '0;
         load_ready          <= 1'b1;
         busy                <= 1'b0;
         core_rstxSO         <= 1'b0;
         encryption_startxSO <= 1'b0;
         keyxSO              <= '0;
         noncexSO            <= '0;
         associated_dataxSO  <= '0;
         plain_textxSO       <= '0;
         r_64xSO             <= '0;
         r_128xSO            <= 1'b0;
         r_ptxSO             <= 1'b0;
      end else begin
         state <= state_d;
         n     <= emit ? nb : state == S_SETTLE ? n + 1'b1 : '0;
         // operands shift left per beat so the MSB is always the next bit to send
         if (accept) begin
            key_q   <= key;
            nonce_q <= nonce;
            ad_q    <= ad;
            pt_q    <= pt;
         end else if (emit) begin
            key_q   <= key_q << 1;
            nonce_q <= nonce_q << 1;
            ad_q    <= ad_q << 1;
            pt_q    <= pt_q << 1;
         end
         load_ready          <= state_d == S_IDLE;
         busy                <= state_d != S_IDLE;
         core_rstxSO         <= state_d == S_PULSE;
         encryption_startxSO <= state_d == S_START;
         keyxSO              <= share(key_q[K-1], m[0], m[1], emit && int'(nb) < K);
         noncexSO            <= share(nonce_q[127], m[2], m[3], emit && int'(nb) < 128);
         associated_dataxSO  <= share(ad_q[L-1], m[4], m[5], emit && int'(nb) < L);
         plain_textxSO       <= share(pt_q[Y-1], m[6], m[7], emit && int'(nb) < Y);
         r_64xSO             <= emit && int'(nb) < 64 ? p[14:8] : '0;
         r_128xSO            <= emit && int'(nb) < 128 && p[15];
         r_ptxSO             <= emit && int'(nb) < Y && p[16];
      end
   end
endmodule

// File: tb/tb_ascon_share_loader.sv
// tb_ascon_share_loader: randomized self-checking bench against a bit-serial share model
module tb_ascon_share_loader;
   localparam logic [63:0] POLY = 64'hD800_0000_0000_0000;
   logic clk = 0, rst = 1, load_valid = 0, load_ready, core_rstxSO, r_128xSO, r_ptxSO;
   logic encryption_startxSO, encryption_readyxSI = 0, busy;
   logic [127:0] key = 0, nonce = 0;
   logic [31:0] ad = 0, pt = 0;
   logic [63:0] seed = 0, ms;
   logic [2:0] keyxSO, noncexSO, associated_dataxSO, plain_textxSO;
   logic [6:0] r_64xSO;
   logic [383:0] t0, t1, t2, tr;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   ascon_share_loader dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .key(key), .nonce(nonce), .ad(ad), .pt(pt), .seed(seed),
      .core_rstxSO(core_rstxSO), .keyxSO(keyxSO), .noncexSO(noncexSO),
      .associated_dataxSO(associated_dataxSO), .plain_textxSO(plain_textxSO),
      .r_64xSO(r_64xSO), .r_128xSO(r_128xSO), .r_ptxSO(r_ptxSO),
      .encryption_startxSO(encryption_startxSO), .encryption_readyxSI(encryption_readyxSI),
      .busy(busy)
   );
   task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic draw(output logic [16:0] b);
      for (int i = 0; i < 17; i++) begin
         b[i] = ms[0];
         ms = (ms >> 1) ^ (ms[0] ? POLY : 64'h0);
      end
   endtask
   function automatic logic [2:0] lane(input logic d, input logic m1, input logic m2, input bit on);
      return on ? {m2, m1, d ^ m1 ^ m2} : 3'b000;
   endfunction
   function automatic logic [26:0] outs();
      return {keyxSO, noncexSO, associated_dataxSO, plain_textxSO, r_64xSO, r_128xSO, r_ptxSO,
              core_rstxSO, encryption_startxSO, busy, load_ready};
   endfunction
   task automatic run_load(input logic [127:0] k, input logic [127:0] nn, input logic [31:0] a,
                           input logic [31:0] p, input logic [63:0] sd, input int hold,
                           input bit early, input int abort_at, output logic [383:0] trace);
      logic [16:0] b;
      logic [7:0] m;
      logic [127:0] kacc, nacc;
      logic [31:0] aacc, pacc;
      logic [26:0] exp;
      trace = '0;
      ms = sd == 64'h0 ? 64'h1 : sd;
      key = k; nonce = nn; ad = a; pt = p; seed = sd; load_valid = 1;
      tick();
      load_valid = 0;
      chk("pulse", {25'b0, core_rstxSO, load_ready}, 27'b10);
      chk("pulse_busy", busy, 1);
      encryption_readyxSI = early;
      tick();
      for (int n = 0; n < 128; n++) begin
         draw(b);
`ifdef ASCON_LOADER_NOMASK_EN
         m = 8'h0;
`else
         m = b[7:0];
`endif
         exp = {lane(k[127-n], m[0], m[1], 1), lane(nn[127-n], m[2], m[3], 1),
                lane(n < 32 ? a[31-n] : 1'b0, m[4], m[5], n < 32),
                lane(n < 32 ? p[31-n] : 1'b0, m[6], m[7], n < 32),
                n < 64 ? b[14:8] : 7'h0, b[15], n < 32 && b[16], 4'b0010};
         chk($sformatf("beat%0d", n), outs(), exp);
         kacc = {kacc[126:0], ^keyxSO};
         nacc = {nacc[126:0], ^noncexSO};
         if (n < 32) begin
            aacc = {aacc[30:0], ^associated_dataxSO};
            pacc = {pacc[30:0], ^plain_textxSO};
         end else chk("ad_pt_idle", {associated_dataxSO, plain_textxSO}, 0);
         trace = {trace[380:0], keyxSO[2:1], r_128xSO};
         if (early && n == 3) begin
            key = ~k; load_valid = 1;
         end
         if (n == abort_at) begin
            rst = 1;
            tick();
            rst = 0; load_valid = 0; encryption_readyxSI = 0;
            chk("abort", outs(), 27'b1);
            return;
         end
         tick();
      end
      load_valid = 0;
      encryption_readyxSI = 0;
      chk("key_reasm", kacc, k);
      chk("nonce_reasm", nacc, nn);
      chk("ad_reasm", aacc, a);
      chk("pt_reasm", pacc, p);
      for (int i = 0; i < 2; i++) begin
         chk("settle", outs(), 27'b10);
         tick();
      end
      for (int i = 0; i < hold; i++) begin
         chk("start_hold", outs(), 27'b110);
         tick();
      end
      encryption_readyxSI = 1;
      tick();
      encryption_readyxSI = 0;
      chk("done_idle", outs(), 27'b1);
   endtask
   initial begin
      tick();
      tick();
      chk("reset", outs(), 27'b1);
      rst = 0;
      tick();
      chk("idle_hold", outs(), 27'b1);
      run_load(128'h000102030405060708090A0B0C0D0E0F, {16{8'hA5}}, 32'hDEADBEEF, 32'h01234567,
               64'h1, 500, 0, -1, t1);
      run_load(128'h000102030405060708090A0B0C0D0E0F, {16{8'hA5}}, 32'hDEADBEEF, 32'h01234567,
               64'h2, 3, 0, -1, t2);
      chk("seed_diff", t1 != t2, 1);
      run_load(128'h000102030405060708090A0B0C0D0E0F, {16{8'hA5}}, 32'hDEADBEEF, 32'h01234567,
               64'h0, 3, 1, -1, t0);
      chk("seed_zero", t0, t1);
      run_load({4{$urandom}}, {4{$urandom}}, $urandom, $urandom, {$urandom, $urandom}, 2, 1, 40, tr);
      tick();
      chk("post_abort_idle", outs(), 27'b1);
      run_load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               $urandom, 32'hFFFF0000, {$urandom, $urandom}, 1, 0, -1, tr);
      for (int r = 0; r < 4; r++)
         run_load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  $urandom, $urandom, {$urandom, $urandom}, int'($urandom_range(1, 6)),
                  1'($urandom_range(0, 1)), -1, tr);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
